// File: rtl/mips_dmem_io_if.sv
// mips_dmem_io_if: core data-port pins plus the TX stream handshake and irq.
interface mips_dmem_io_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        irq;
  modport slave (input memwrite, addr, writedata, out_ready, output readdata, out_valid, out_data, irq);
  modport master (output memwrite, addr, writedata, out_ready, input readdata, out_valid, out_data, irq);
endinterface

// File: rtl/mips_dmem_io.sv
// mips_dmem_io: data RAM plus I/O page (cycle counter, compare timer, TX FIFO).
module mips_dmem_io #(
  parameter int RAM_AW = 6,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  mips_dmem_io_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  logic [31:0]       mem [2**RAM_AW];
  logic [31:0]       count_q, count_d, cmp_q, cmp_d;
  logic              tflag_q, tflag_d, ovf_q, ovf_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [31:0]       buf_q [DEPTH];
  logic [31:0]       buf_d [DEPTH];
  logic              is_ram, is_io, wr_io, push, pop, push_ok, clr, unused;
  logic [1:0]        off;
  logic [RAM_AW-1:0] idx;
  logic [31:0]       status, io_rd;
  assign is_ram  = !bus.addr[31];
  assign is_io   = bus.addr[31:4] == 28'hFFFF000;
  assign off     = bus.addr[3:2];
  assign idx     = bus.addr[RAM_AW+1:2];
  assign wr_io   = bus.memwrite && is_io;
  assign clr     = wr_io && off == 2'd2;
  assign push    = wr_io && off == 2'd3;
  assign pop     = bus.out_valid && bus.out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (occ_q < OW'(DEPTH) || pop);
  assign unused  = &{1'b0, bus.addr[1:0]};
  assign status  = {24'd0, 4'(occ_q), ovf_q, occ_q == '0, occ_q == OW'(DEPTH), tflag_q};
  assign io_rd   = off == 2'd0 ? count_q : off == 2'd1 ? cmp_q : off == 2'd2 ? status : '0;
  assign bus.readdata  = is_ram ? mem[idx] : is_io ? io_rd : '0;
  assign bus.out_valid = occ_q != '0;
  assign bus.out_data  = buf_q[rp_q];
  assign bus.irq       = tflag_q;
  always_comb begin
    count_d = (wr_io && off == 2'd0) ? bus.writedata : count_q + 32'd1;
    cmp_d   = (wr_io && off == 2'd1) ? bus.writedata : cmp_q;
    tflag_d = (count_q == cmp_q) || (tflag_q && !(clr && bus.writedata[0]));
    ovf_d   = (push && !push_ok) || (ovf_q && !(clr && bus.writedata[3]));
    wp_d    = wp_q + PW'(push_ok);
    rp_d    = rp_q + PW'(pop);
    occ_d   = occ_q + OW'(push_ok) - OW'(pop);
    for (int i = 0; i < DEPTH; i++) buf_d[i] = (push_ok && wp_q == PW'(i)) ? bus.writedata : buf_q[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      cmp_q   <= '1;
      tflag_q <= 1'b0;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      occ_q   <= '0;
      buf_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      tflag_q <= tflag_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
      buf_q   <= buf_d;
    end
  end
  // RAM keeps its contents through reset; only the write strobe is gated.
  always_ff @(posedge clk) begin
    if (bus.memwrite && is_ram && !reset) mem[idx] <= bus.writedata;
  end
endmodule

// File: doc/mips_dmem_io.md
# mips_dmem_io

Data-port responder for the single-cycle MIPS core. It decodes the core's data address and services each access from one of two places: a word-addressed data RAM, or a small memory-mapped I/O page. The I/O page holds a free-running cycle counter, a compare timer with a sticky flag and interrupt, and a transmit FIFO drained by an external consumer over a valid/ready handshake. It sits between the core's `aluout`/`writedata`/`memwrite`/`readdata` pins and the top level, replacing the bare data memory.

## Interface
- `RAM_AW`, 6: log2 of RAM depth in words (64 words).
- `DEPTH`, 4: TX FIFO entries; power of two, 2..8.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `memwrite` in 1: write strobe from core, sampled at the rising edge.
- `addr` in 32: byte address (core `aluout`); `addr[1:0]` ignored.
- `writedata` in 32: store data from core.
- `readdata` out 32: load data to core; combinational from `addr`.
- `out_valid` out 1: FIFO head valid (FIFO not empty).
- `out_data` out 32: FIFO head word.
- `out_ready` in 1: consumer accepts head this cycle.
- `irq` out 1: equals timer flag.

## Operation
- **Decode**
  - `addr[31]==0`: RAM, word index `addr[RAM_AW+1:2]`; upper bits aliased.
  - `addr[31:4]==28'hFFFF000`: I/O page.
  - Anything else: reads return 0, writes ignored.
- **RAM**
  - Write on the edge when `memwrite`.
  - Read is combinational.
  - Contents not reset.
- **I/O registers** (offset `addr[3:2]`)
  - 0 COUNT: reads the counter. A write loads `writedata`, and the load overrides the increment that cycle. Otherwise the counter increments every cycle and wraps 0xFFFFFFFF→0.
  - 1 CMP: R/W compare value; reset 0xFFFFFFFF.
  - 2 STATUS, read layout:
    - [0] tflag
    - [1] full
    - [2] empty
    - [3] ovf
    - [7:4] FIFO occupancy
    - other bits 0
  - 2 STATUS, write: write-1-to-clear on bits 0 and 3; other bits ignored.
  - 3 TXDATA: a write pushes `writedata`. Reads return 0.
- **Timer flag**
  - Set at the edge where the current (pre-update) COUNT equals CMP.
  - A set and a W1C in the same cycle: set wins.
  - `irq` = tflag.
- **FIFO**
  - Circular buffer with read/write pointers and occupancy counter.
  - Pop when `out_valid && out_ready`.
  - Push is accepted if occupancy < DEPTH, or if a pop occurs in the same cycle.
  - A rejected push sets sticky `ovf` and the data is dropped.
  - Simultaneous push and pop with occupancy 0: no bypass. The word appears next cycle.
  - `out_data` = entry at the read pointer. Storage resets to 0.

## Timing
- **Reset values:**
  - COUNT=0, CMP=0xFFFFFFFF, tflag=0, ovf=0
  - FIFO empty, `out_valid`=0, `out_data`=0, `irq`=0
  - STATUS reads 0x00000004
- `readdata` has zero latency: it is valid in the same cycle as `addr`, so the single-cycle core loads without a stall.
- Writes take effect at the edge ending the access cycle. A read of the same location in the next cycle returns the new value.
- Push-to-`out_valid` latency is 1 cycle.
- `out_data` is stable while `out_valid` is high and `out_ready` is low.
- Pop advances the head at the edge. With back-to-back ready, one word is delivered per cycle.
- COUNT matches CMP for only one cycle per wrap. A CMP write equal to the current COUNT sets the flag only if COUNT still equals CMP at a later edge.
- Reset asserted mid-operation:
  - All registers and FIFO state return to reset values immediately, without waiting for an edge.
  - RAM is untouched.
  - A write in flight is lost.

## Test plan
- **Reset and RAM:** assert reset, then release.
  - STATUS=0x4; COUNT read at cycle 0 after release = 0.
  - Store 0xDEADBEEF to 0x00000010, then load 0x00000010 → 0xDEADBEEF.
  - Load 0x00000110 (alias with RAM_AW=6) → 0xDEADBEEF.
- **Timer:**
  - Write CMP=20 and COUNT=10.
  - 10 cycles later tflag=1 and `irq`=1.
  - Write STATUS=0x1 → tflag=0 next cycle.
  - Write COUNT=0xFFFFFFFE → reads 0 after two increments (wrap).
- **FIFO fill and overflow:** hold `out_ready`=0, push 1..5.
  - After 4 pushes: STATUS=0x42 (occupancy 4, full).
  - 5th push is dropped and sets ovf: STATUS=0x4A.
  - Raise `out_ready`: `out_data` sequence 1,2,3,4, then `out_valid`=0, STATUS=0x0C.
- **Simultaneous push/pop when full:**
  - Fill with A..D, hold `out_ready`=1, push E the same cycle.
  - A pops, E is accepted, occupancy stays 4, ovf=0.
- **Flag set/clear collision:**
  - Write STATUS=0x1 in the cycle where COUNT==CMP → tflag remains 1.
- **Async reset mid-stream:**
  - With 3 words queued and the counter running, pulse reset between edges.
  - `out_valid`=0 and `irq`=0 immediately.
  - RAM word at 0x10 is still readable.
